rom_image_streamer: RTL and testbench

ROM_IMAGE_STREAMER -- requirements
Module: rom_image_streamer

---
 rtl/rom_image_streamer.sv | 175 +++++++++++++++++
 tb/tb_rom_image_streamer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_image_streamer.sv
// Streams a ROM image (address 0 .. 2**ADDR_WIDTH-1) onto a valid/ready bus with frame/line flags.
// Optional: define ROM_IMAGE_STREAMER_LOOP_EN to repeat frames back-to-back forever after one start.
module rom_image_streamer #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 2,
  parameter int LINE_WORDS = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_rd_en,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  m_eof,
  output logic                  busy
);

`ifdef ROM_IMAGE_STREAMER_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int LCW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int CRW = $clog2(FIFO_DEPTH + RD_LATENCY + 2) + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    rd_en_q;
  logic [LCW-1:0]          line_q;
  logic                    busy_q;
  logic [RD_LATENCY-1:0]   vld_pipe_q;
  logic [2:0]              flg_pipe_q [RD_LATENCY];
  logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
  logic [2:0]              fmem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q;
  logic [PW-1:0]           rd_ptr_q;
  logic [CW-1:0]           cnt_q;

  logic                    push_s;
  logic                    pop_s;
  logic [CRW-1:0]          inflight_s;
  logic [CRW-1:0]          outstanding_s;
  logic                    credit_ok_s;
  logic                    is_last_s;
  logic                    is_eol_s;
  logic [2:0]              issue_flags_s;
  logic [ADDR_WIDTH-1:0]   addr_nxt_s;
  logic [LCW-1:0]          line_nxt_s;

  // Credit check counts the word being issued now plus every read still in the ROM pipeline.
  always_comb begin
    pop_s      = (cnt_q != {CW{1'b0}}) && m_ready;
    push_s     = vld_pipe_q[RD_LATENCY-1];
    inflight_s = CRW'(rd_en_q);
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_s = inflight_s + CRW'(vld_pipe_q[i]);
    end
    outstanding_s = CRW'(cnt_q) + inflight_s - CRW'(pop_s);
    credit_ok_s   = (outstanding_s < CRW'(FIFO_DEPTH));
    is_last_s     = (addr_q == LAST_ADDR);
    is_eol_s      = (line_q == LCW'(LINE_WORDS - 1)) || is_last_s;
    issue_flags_s = {is_last_s, is_eol_s, (addr_q == {ADDR_WIDTH{1'b0}})};
    addr_nxt_s    = addr_q + ADDR_WIDTH'(1'b1);
    line_nxt_s    = is_eol_s ? {LCW{1'b0}} : (line_q + LCW'(1'b1));
  end

  // Frame control FSM; also owns the registered ROM read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= {ADDR_WIDTH{1'b0}};
      rd_en_q <= 1'b0;
      line_q  <= {LCW{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rd_en_q <= start;
          if (start) begin
            state_q <= ST_RUN;
            addr_q  <= {ADDR_WIDTH{1'b0}};
            line_q  <= {LCW{1'b0}};
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (rd_en_q) begin
            addr_q <= addr_nxt_s;
            line_q <= line_nxt_s;
          end
          if (rd_en_q && is_last_s && !LOOP_EN) begin
            state_q <= ST_DRAIN;
            rd_en_q <= 1'b0;
          end else begin
            rd_en_q <= credit_ok_s;
          end
        end
        ST_DRAIN: begin
          rd_en_q <= 1'b0;
          if (pop_s && fmem_q[rd_ptr_q][2]) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          rd_en_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Flag pipeline tracks each read through the ROM latency, then lands data and flags in the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= {RD_LATENCY{1'b0}};
      for (int i = 0; i < RD_LATENCY; i++) flg_pipe_q[i] <= 3'b000;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i]  <= {DATA_WIDTH{1'b0}};
        fmem_q[i] <= 3'b000;
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      cnt_q    <= {CW{1'b0}};
    end else begin
      vld_pipe_q[0] <= rd_en_q;
      flg_pipe_q[0] <= issue_flags_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        flg_pipe_q[i] <= flg_pipe_q[i-1];
      end
      if (push_s) begin
        mem_q[wr_ptr_q]  <= rom_rd_data;
        fmem_q[wr_ptr_q] <= flg_pipe_q[RD_LATENCY-1];
        wr_ptr_q         <= wr_ptr_q + PW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_q <= cnt_q + CW'(1'b1);
        2'b01:   cnt_q <= cnt_q - CW'(1'b1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign rom_addr  = addr_q;
  assign rom_rd_en = rd_en_q;
  assign busy      = busy_q;
  assign m_valid   = (cnt_q != {CW{1'b0}});
  assign m_data    = mem_q[rd_ptr_q];
  assign m_sof     = fmem_q[rd_ptr_q][0];
  assign m_eol     = fmem_q[rd_ptr_q][1];
  assign m_eof     = fmem_q[rd_ptr_q][2];

endmodule

// File: tb/tb_rom_image_streamer.sv
// Bench for rom_image_streamer: small image (16 words, 4-word lines), ROM word = address,
// random backpressure, stall, restart-ignore and mid-frame reset scenarios.
module tb_rom_image_streamer;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int RL = 2;
  localparam int LW = 4;
  localparam int FD = 4;
  localparam int NW = 16;
`ifdef ROM_IMAGE_STREAMER_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          m_ready = 1'b0;
  logic [AW-1:0] rom_addr;
  logic          rom_rd_en;
  logic [DW-1:0] rom_rd_data;
  logic [DW-1:0] m_data;
  logic          m_valid, m_sof, m_eol, m_eof, busy;
  logic [DW-1:0] rom_pipe [RL];

  int n_checks = 0;
  int n_fail = 0;
  int xfers = 0;
  int issued = 0;
  int cyc = 0;
  int first_cyc = 0;
  int eof_cyc = 0;
  int rdy_mode = 0;
  int lat;
  bit prev_stall = 1'b0;
  bit busy_pend = 1'b0;
  logic [DW-1:0] prev_data;
  logic [2:0] prev_flags;

  rom_image_streamer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(RL), .LINE_WORDS(LW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rom_addr(rom_addr), .rom_rd_en(rom_rd_en), .rom_rd_data(rom_rd_data),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof), .busy(busy)
  );

  always #5 clk = ~clk;

  // ROM model: word equals its address, data valid RL cycles after the address is presented
  always @(posedge clk) begin
    rom_pipe[0] <= DW'(rom_addr);
    for (int i = 1; i < RL; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_rd_data = rom_pipe[RL-1];

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic clear_sb();
    xfers = 0;
    issued = 0;
  endtask

  task automatic wait_xfers(input string tag, input int n, input int budget);
    int k = 0;
    while (xfers < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, longint'(xfers >= n), 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_addr"}, rom_addr, 0);
    chk({tag, "_rd_en"}, rom_rd_en, 0);
    chk({tag, "_data"}, m_data, 0);
    chk({tag, "_valid"}, m_valid, 0);
    chk({tag, "_flags"}, {m_sof, m_eol, m_eof}, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Backpressure driver: 0 = always ready, 1 = random 50%, 2 = never ready
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'($urandom % 2);
      default: m_ready = 1'b0;
    endcase
  end

  // Scoreboard: transfer k must carry word k mod NW with flags derived from its index
  initial forever begin
    int w;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
      busy_pend  = 1'b0;
    end else begin
      if (busy_pend) begin
        chk("busy_after_eof", busy, LOOP ? 1 : 0);
        busy_pend = 1'b0;
      end
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, prev_data);
        chk("hold_flags", {m_sof, m_eol, m_eof}, prev_flags);
      end
      if (rom_rd_en) issued++;
      if (m_valid && m_ready) begin
        w = xfers % NW;
        chk("data", m_data, w);
        chk("sof", m_sof, longint'(w == 0));
        chk("eol", m_eol, longint'((w % LW) == LW - 1));
        chk("eof", m_eof, longint'(w == NW - 1));
        chk("busy_during", busy, 1);
        if (w == 0) first_cyc = cyc;
        if (w == NW - 1) begin
          eof_cyc = cyc;
          busy_pend = 1'b1;
        end
        xfers++;
      end
      chk("credit", longint'((issued - xfers) <= FD), 1);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_flags = {m_sof, m_eol, m_eof};
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    clear_sb();
`ifdef ROM_IMAGE_STREAMER_LOOP_EN
    rdy_mode = 0;
    pulse_start();
    repeat (20) @(posedge clk);
    pulse_start();
    wait_xfers("loop_xfers", 40, 100);
    chk("loop_wrap_gap", first_cyc - eof_cyc, 1);
    chk("loop_busy", busy, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check_outputs_zero("loop_rst");
`else
    // Full-rate frame: latency, flags, gapless delivery, busy fall
    rdy_mode = 0;
    pulse_start();
    lat = 0;
    while (!m_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("first_valid_latency", lat, RL + 1);
    wait_xfers("t1_done", NW, 100);
    chk("t1_consecutive", eof_cyc - first_cyc, NW - 1);
    repeat (5) @(negedge clk);
    chk("t1_busy_idle", busy, 0);
    chk("t1_count", xfers, NW);
    chk("t1_issued", issued, NW);

    // Random backpressure frames with random idle gaps
    for (int f = 0; f < 3; f++) begin
      clear_sb();
      rdy_mode = 1;
      repeat ($urandom_range(1, 5)) @(posedge clk);
      pulse_start();
      wait_xfers("rand_done", NW, 600);
      repeat (10) @(negedge clk);
      chk("rand_count", xfers, NW);
      chk("rand_busy", busy, 0);
    end

    // Full stall: only FIFO_DEPTH reads may issue
    clear_sb();
    rdy_mode = 2;
    pulse_start();
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("stall_issued", issued, FD);
    chk("stall_rd_en", rom_rd_en, 0);
    chk("stall_data", m_data, 0);
    chk("stall_valid", m_valid, 1);
    chk("stall_sof", m_sof, 1);
    rdy_mode = 0;
    wait_xfers("stall_done", NW, 100);
    repeat (5) @(negedge clk);
    chk("stall_count", xfers, NW);

    // Second start during RUN must be ignored
    clear_sb();
    rdy_mode = 1;
    pulse_start();
    repeat (6) @(posedge clk);
    pulse_start();
    wait_xfers("restart_done", NW, 600);
    repeat (30) @(negedge clk);
    chk("restart_count", xfers, NW);
    chk("restart_issued", issued, NW);
    chk("restart_busy", busy, 0);

    // Reset mid-frame after word 6, then a clean frame from word 0
    clear_sb();
    rdy_mode = 0;
    pulse_start();
    wait_xfers("pre_rst", 7, 100);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check_outputs_zero("mid_rst");
    clear_sb();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_valid", m_valid, 0);
    chk("post_rst_rd_en", rom_rd_en, 0);
    chk("post_rst_busy", busy, 0);
    pulse_start();
    wait_xfers("post_rst_done", NW, 100);
    repeat (5) @(negedge clk);
    chk("post_rst_count", xfers, NW);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
